// File: rtl/sipo_rx_pkg.sv
// Shared types and helpers for the serial frame receiver.
// State encoding, frame length and parity check.
package sipo_rx_pkg;

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      PARITY,
      STOP
   } rx_state_t;

   function automatic int unsigned frame_len(
      input int unsigned data_w,
      input bit          parity_en
   );
      return data_w + 2 + (parity_en ? 1 : 0);
   endfunction

   // 1 when the received parity bit disagrees with the data
   function automatic logic parity_err_calc(
      input logic [31:0] data,
      input logic        par_bit,
      input logic        odd
   );
      return ((^data) ^ par_bit) != odd;
   endfunction

endpackage

// File: rtl/rx_out_buf.sv
// One-entry valid/ready holding register for a received word.
// A load while full is dropped unless the entry pops on that edge.
module rx_out_buf #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] ld_data,
   input  logic         ld_perr,
   input  logic         ld_ferr,
   input  logic         ready,
   output logic [W-1:0] data,
   output logic         valid,
   output logic         perr,
   output logic         ferr,
   output logic         overrun
);

   logic [W-1:0] data_q, data_d;
   logic         valid_q, valid_d;
   logic         perr_q, perr_d;
   logic         ferr_q, ferr_d;
   logic         ovr_q, ovr_d;
   logic         pop;

   // Load/pop/drop decision for the single entry
   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      perr_d  = perr_q;
      ferr_d  = ferr_q;
      ovr_d   = 1'b0;
      pop     = valid_q & ready;
      if (load) begin
         if (!valid_q || pop) begin
            data_d  = ld_data;
            perr_d  = ld_perr;
            ferr_d  = ld_ferr;
            valid_d = 1'b1;
         end else begin
            ovr_d = 1'b1;
         end
      end else if (pop) begin
         valid_d = 1'b0;
      end
   end

   // Entry registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         data_q  <= '0;
         valid_q <= 1'b0;
         perr_q  <= 1'b0;
         ferr_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
         perr_q  <= perr_d;
         ferr_q  <= ferr_d;
         ovr_q   <= ovr_d;
      end
   end

   assign data    = data_q;
   assign valid   = valid_q;
   assign perr    = perr_q;
   assign ferr    = ferr_q;
   assign overrun = ovr_q;

endmodule

// File: rtl/sipo_frame_rx.sv
// Serial frame receiver: start bit, MSB-first data, optional
// parity, stop bit; word handed off through rx_out_buf.
module sipo_frame_rx
   import sipo_rx_pkg::*;
#(
   parameter int unsigned DATA_W     = 8,
   parameter bit          PARITY_EN  = 1'b1,
   parameter bit          PARITY_ODD = 1'b0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              serial_in,
   output logic [DATA_W-1:0] data_out,
   output logic              data_valid,
   input  logic              data_ready,
   output logic              parity_err,
   output logic              frame_err,
   output logic              overrun
);

   localparam int unsigned CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

   rx_state_t         state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic              perr_q, perr_d;
   logic              load;
   logic              ld_ferr;
   logic              ld_perr;

   // Next-state, shift and completion logic
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      shift_d = shift_q;
      perr_d  = perr_q;
      load    = 1'b0;
      ld_ferr = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (serial_in) begin
               state_d = DATA;
               cnt_d   = '0;
               perr_d  = 1'b0;
            end
         end
         DATA: begin
            shift_d = {shift_q[DATA_W-2:0], serial_in};
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               state_d = PARITY_EN ? PARITY : STOP;
            end
         end
         PARITY: begin
            perr_d  = parity_err_calc(32'(shift_q), serial_in,
                                      PARITY_ODD);
            state_d = STOP;
         end
         STOP: begin
            load    = 1'b1;
            ld_ferr = serial_in;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Receiver state registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         shift_q <= '0;
         perr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
         perr_q  <= perr_d;
      end
   end

   assign ld_perr = PARITY_EN & perr_q;

   rx_out_buf #(
      .W (DATA_W)
   ) u_buf (
      .clk     (clk),
      .reset   (reset),
      .load    (load),
      .ld_data (shift_q),
      .ld_perr (ld_perr),
      .ld_ferr (ld_ferr),
      .ready   (data_ready),
      .data    (data_out),
      .valid   (data_valid),
      .perr    (parity_err),
      .ferr    (frame_err),
      .overrun (overrun)
   );

endmodule

// File: tb/tb_sipo_frame_rx.sv
// Self-checking bench for sipo_frame_rx (DATA_W=8, even parity).
// Frame-level reference model driven by the stimulus generator.
module tb_sipo_frame_rx;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         reset;
   logic         serial_in;
   logic         data_ready;
   logic [W-1:0] data_out;
   logic         data_valid;
   logic         parity_err;
   logic         frame_err;
   logic         overrun;

   logic         siso_en = 1'b0;
   logic [3:0]   siso_q = 4'h0;
   logic         line;

   int n_chk = 0;
   int n_fail = 0;

   logic         m_valid;
   logic [W-1:0] m_data;
   logic         m_perr;
   logic         m_ferr;
   logic         m_ovr;

   always #5 clk = ~clk;

   // upstream 4-bit serial delay stage
   always @(posedge clk) siso_q <= {siso_q[2:0], serial_in};
   assign line = siso_en ? siso_q[3] : serial_in;

   sipo_frame_rx #(
      .DATA_W     (W),
      .PARITY_EN  (1'b1),
      .PARITY_ODD (1'b0)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .serial_in  (line),
      .data_out   (data_out),
      .data_valid (data_valid),
      .data_ready (data_ready),
      .parity_err (parity_err),
      .frame_err  (frame_err),
      .overrun    (overrun)
   );

   task automatic model_reset();
      m_valid = 0; m_data = '0; m_perr = 0; m_ferr = 0; m_ovr = 0;
   endtask

   // one line bit; done marks the stop-bit edge of a frame
   task automatic step(input logic b, input logic rdy,
                       input logic done, input logic [W-1:0] w,
                       input logic pe, input logic fe);
      logic pop;
      @(negedge clk);
      serial_in = b;
      data_ready = rdy;
      @(posedge clk);
      pop = m_valid && rdy;
      m_ovr = 0;
      if (done) begin
         if (!m_valid || pop) begin
            m_valid = 1; m_data = w; m_perr = pe; m_ferr = fe;
         end else begin
            m_ovr = 1;
         end
      end else if (pop) begin
         m_valid = 0;
      end
      #1;
   endtask

   task automatic send_frame(input logic [W-1:0] w, input logic flip_par,
                             input logic sb, input logic rdy,
                             input logic rdy_last);
      step(1'b1, rdy, 1'b0, '0, 1'b0, 1'b0);
      for (int i = W - 1; i >= 0; i--)
         step(w[i], rdy, 1'b0, '0, 1'b0, 1'b0);
      step((^w) ^ flip_par, rdy, 1'b0, '0, 1'b0, 1'b0);
      step(sb, rdy_last, 1'b1, w, flip_par, sb);
   endtask

   task automatic idle(input int n, input logic rdy);
      for (int i = 0; i < n; i++) step(1'b0, rdy, 1'b0, '0, 1'b0, 1'b0);
   endtask

   task automatic test_reset();
      reset = 1'b0; serial_in = 1'b0; data_ready = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      n_chk++;
      if ({data_out, data_valid, parity_err, frame_err, overrun} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %h expected 0",
                  {data_out, data_valid, parity_err, frame_err, overrun});
      end
      @(negedge clk); reset = 1'b1;
      idle(2, 1'b1);
      n_chk++;
      if (data_valid !== 1'b0) begin
         n_fail++; $display("FAIL idle_after_reset: valid=%b expected 0", data_valid);
      end
   endtask

   task automatic test_clean();
      send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 1'b1);
      n_chk++;
      if ({data_valid, data_out, parity_err, frame_err} !== {1'b1, 8'hA5, 2'b00}) begin
         n_fail++;
         $display("FAIL clean_frame: v=%b d=%h pe=%b fe=%b expected 1 a5 0 0",
                  data_valid, data_out, parity_err, frame_err);
      end
      idle(1, 1'b1);
      n_chk++;
      if ({data_valid, data_out} !== {1'b0, 8'hA5}) begin
         n_fail++;
         $display("FAIL clean_pop: v=%b d=%h expected 0 a5", data_valid, data_out);
      end
   endtask

   task automatic test_errors();
      send_frame(8'hA5, 1'b1, 1'b0, 1'b1, 1'b1);
      n_chk++;
      if ({data_valid, data_out, parity_err, frame_err} !== {1'b1, 8'hA5, 2'b10}) begin
         n_fail++;
         $display("FAIL parity_err: v=%b d=%h pe=%b fe=%b expected 1 a5 1 0",
                  data_valid, data_out, parity_err, frame_err);
      end
      idle(1, 1'b1);
      send_frame(8'h3C, 1'b0, 1'b1, 1'b1, 1'b1);
      n_chk++;
      if ({data_valid, data_out, parity_err, frame_err} !== {1'b1, 8'h3C, 2'b01}) begin
         n_fail++;
         $display("FAIL frame_err: v=%b d=%h pe=%b fe=%b expected 1 3c 0 1",
                  data_valid, data_out, parity_err, frame_err);
      end
      idle(2, 1'b1);
   endtask

   task automatic test_overrun();
      send_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b0);
      send_frame(8'h22, 1'b0, 1'b0, 1'b0, 1'b0);
      n_chk++;
      if ({data_valid, data_out, overrun} !== {1'b1, 8'h11, 1'b1}) begin
         n_fail++;
         $display("FAIL overrun_drop: v=%b d=%h ov=%b expected 1 11 1",
                  data_valid, data_out, overrun);
      end
      idle(1, 1'b0);
      n_chk++;
      if ({data_valid, data_out, overrun} !== {1'b1, 8'h11, 1'b0}) begin
         n_fail++;
         $display("FAIL overrun_once: v=%b d=%h ov=%b expected 1 11 0",
                  data_valid, data_out, overrun);
      end
      idle(1, 1'b1);
      n_chk++;
      if (data_valid !== 1'b0) begin
         n_fail++; $display("FAIL overrun_pop: valid=%b expected 0", data_valid);
      end
   endtask

   task automatic test_pop_at_completion();
      send_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b0);
      send_frame(8'h22, 1'b0, 1'b0, 1'b0, 1'b1);
      n_chk++;
      if ({data_valid, data_out, overrun} !== {1'b1, 8'h22, 1'b0}) begin
         n_fail++;
         $display("FAIL pop_and_load: v=%b d=%h ov=%b expected 1 22 0",
                  data_valid, data_out, overrun);
      end
      idle(1, 1'b0);
      n_chk++;
      if ({data_valid, data_out, overrun} !== {1'b1, 8'h22, 1'b0}) begin
         n_fail++;
         $display("FAIL pop_and_load_hold: v=%b d=%h ov=%b expected 1 22 0",
                  data_valid, data_out, overrun);
      end
      idle(1, 1'b1);
   endtask

   task automatic test_reset_midframe();
      send_frame(8'h77, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
      for (int i = 7; i >= 4; i--)
         step(W'(8'h5A) >> i, 1'b0, 1'b0, '0, 1'b0, 1'b0);
      @(negedge clk);
      reset = 1'b0; serial_in = 1'b1;
      model_reset();
      #1;
      n_chk++;
      if ({data_out, data_valid, parity_err, frame_err, overrun} !== '0) begin
         n_fail++;
         $display("FAIL reset_midframe: got %h expected 0",
                  {data_out, data_valid, parity_err, frame_err, overrun});
      end
      repeat (2) @(posedge clk);
      #1;
      n_chk++;
      if ({data_out, data_valid, parity_err, frame_err, overrun} !== '0) begin
         n_fail++;
         $display("FAIL reset_held: got %h expected 0",
                  {data_out, data_valid, parity_err, frame_err, overrun});
      end
      @(negedge clk); reset = 1'b1; serial_in = 1'b0;
      idle(12, 1'b1);
      n_chk++;
      if (data_valid !== 1'b0) begin
         n_fail++; $display("FAIL no_spurious: valid=%b expected 0", data_valid);
      end
      send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 1'b1);
      n_chk++;
      if ({data_valid, data_out, parity_err, frame_err} !== {1'b1, 8'h5A, 2'b00}) begin
         n_fail++;
         $display("FAIL after_reset: v=%b d=%h pe=%b fe=%b expected 1 5a 0 0",
                  data_valid, data_out, parity_err, frame_err);
      end
      idle(2, 1'b1);
   endtask

   task automatic test_random();
      logic [W-1:0] w;
      logic fp, sb, r;
      logic bits[$];
      int last;
      for (int f = 0; f < 150; f++) begin
         w = W'($urandom);
         fp = ($urandom_range(0, 3) == 0);
         sb = ($urandom_range(0, 3) == 0);
         bits = {};
         bits.push_back(1'b1);
         for (int i = W - 1; i >= 0; i--) bits.push_back(w[i]);
         bits.push_back((^w) ^ fp);
         bits.push_back(sb);
         last = bits.size() - 1;
         repeat ($urandom_range(0, 2)) bits.push_back(1'b0);
         for (int i = 0; i < bits.size(); i++) begin
            r = 1'($urandom_range(0, 1));
            step(bits[i], r, (i == last), w, fp, sb);
            n_chk++;
            if ({data_valid, data_out, parity_err, frame_err, overrun} !==
                {m_valid, m_data, m_perr, m_ferr, m_ovr}) begin
               n_fail++;
               $display("FAIL random f%0d b%0d: got v=%b d=%h pe=%b fe=%b ov=%b expected v=%b d=%h pe=%b fe=%b ov=%b",
                        f, i, data_valid, data_out, parity_err, frame_err, overrun,
                        m_valid, m_data, m_perr, m_ferr, m_ovr);
            end
         end
      end
      idle(3, 1'b1);
   endtask

   // edges from the start-bit edge to data_valid; -1 if none
   task automatic measure(input logic via, output int lat,
                          output logic [W-1:0] d);
      logic [W-1:0] w;
      logic bits[$];
      w = 8'hC3;
      idle(6, 1'b1);
      siso_en = via;
      bits = {};
      bits.push_back(1'b1);
      for (int i = W - 1; i >= 0; i--) bits.push_back(w[i]);
      bits.push_back(^w);
      bits.push_back(1'b0);
      repeat (10) bits.push_back(1'b0);
      lat = -1;
      d = '0;
      for (int i = 0; i < bits.size(); i++) begin
         step(bits[i], 1'b1, 1'b0, '0, 1'b0, 1'b0);
         if (lat < 0 && data_valid) begin
            lat = i; d = data_out;
         end
      end
      siso_en = 1'b0;
   endtask

   task automatic test_siso_chain();
      int lat_d, lat_c;
      logic [W-1:0] d_d, d_c;
      measure(1'b0, lat_d, d_d);
      measure(1'b1, lat_c, d_c);
      n_chk++;
      if (lat_d !== 10) begin
         n_fail++; $display("FAIL latency_direct: got %0d expected 10", lat_d);
      end
      n_chk++;
      if (lat_c !== lat_d + 4) begin
         n_fail++; $display("FAIL latency_chain: got %0d expected %0d", lat_c, lat_d + 4);
      end
      n_chk++;
      if (d_c !== 8'hC3) begin
         n_fail++; $display("FAIL chain_data: got %h expected c3", d_c);
      end
   endtask

   initial begin
      test_reset();
      test_clean();
      test_errors();
      test_overrun();
      test_pop_at_completion();
      test_reset_midframe();
      test_random();
      test_siso_chain();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/sipo_frame_rx.md
# sipo_frame_rx

Serial-to-parallel frame receiver that sits directly downstream of the 4-bit serial-in/serial-out delay stage and consumes its `serial_out` bit stream. It samples one bit per clock, detects a start bit, deserializes a DATA_W-bit word MSB-first, checks optional parity and the stop bit, and presents the word plus error flags through a one-entry valid/ready output buffer. Frames that arrive while the buffer is still occupied are dropped and flagged as overrun.

## Interface
- DATA_W, 8, data bits per frame (2..32)
- PARITY_EN, 1, 1 = parity bit present after the data bits
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity
- clk  in  1  rising-edge clock; one line bit per cycle
- reset  in  1  asynchronous, active-low reset
- serial_in  in  1  line bit; idle level 0
- data_out  out  DATA_W  received word, MSB is the first data bit received
- data_valid  out  1  data_out, parity_err and frame_err are valid
- data_ready  in  1  consumer accepts the word at the edge where valid && ready
- parity_err  out  1  parity mismatch on the buffered word
- frame_err  out  1  stop bit was 1 on the buffered word
- overrun  out  1  one-cycle pulse: a completed frame was dropped

## Operation
- Frame format: start bit 1, DATA_W data bits MSB-first, parity bit (if PARITY_EN), stop bit 0. Frame length is DATA_W+2+PARITY_EN bits.
- States: IDLE, DATA, PARITY, STOP.
- IDLE: serial_in = 1 goes to DATA and clears the bit counter. serial_in = 0 stays in IDLE.
- DATA: shift serial_in into the LSB of the shift register and increment the counter. After DATA_W bits, go to PARITY if PARITY_EN, otherwise to STOP.
- PARITY: capture the bit. The error condition is (^data ^ bit) != PARITY_ODD.
- STOP: sample the stop bit, then always return to IDLE. The frame is now complete, with frame_err = stop bit.
- Completed frames with errors are still delivered; the error flags travel with the word.
- Output buffer load at frame completion:
  - Buffer empty, or valid && ready at the same edge: load data_out, parity_err and frame_err, and hold data_valid at 1.
  - Otherwise: drop the frame, keep the buffer unchanged, and pulse overrun for one cycle.
- valid && ready with no completion at that edge: data_valid goes to 0. data_out keeps its last value.
- While data_valid is 1 and data_ready is 0, data_out, parity_err and frame_err hold stable.
- A stop bit of 1 does not start a new frame. The receiver re-enters IDLE and samples the next cycle.
- The parity flag is forced to 0 when PARITY_EN = 0.

## Timing
- Reset asserted: state IDLE, counter 0, shift register 0, and every output at 0 (data_out, data_valid, parity_err, frame_err, overrun). This holds at any point, including mid-frame; a partial frame is discarded silently.
- Latency: data_valid rises at the same edge that samples the stop bit. For DATA_W=8 with parity, that is 10 edges after the edge that sampled the start bit.
- Back-to-back frames: a start bit in the cycle right after the stop bit is accepted. Sustained throughput is one word per frame length.
- overrun is high for exactly the cycle following the dropping edge.
- data_ready is ignored while data_valid is 0.

## Structure
- Package sipo_rx_pkg holds:
  - the state enum `rx_state_t` (IDLE, DATA, PARITY, STOP);
  - a frame-length function of (DATA_W, PARITY_EN);
  - a parity helper function.
- Sub-module rx_out_buf: one-entry valid/ready holding register for {data, parity_err, frame_err}. It has a load input and an overrun output, and implements the simultaneous load/pop rule.
- Top level: FSM, bit counter ($clog2(DATA_W) bits) and shift register.

## Test plan
- Clean frame, DATA_W=8, even parity. Drive 1, then 1,0,1,0,0,1,0,1, then 0, then 0, with data_ready=1 → data_out=8'hA5, data_valid for 1 cycle, parity_err=0, frame_err=0.
- Same frame with parity bit 1 → data_out=8'hA5 with parity_err=1. Then stop bit 1 on 8'h3C (parity 0) → frame_err=1, parity_err=0.
- data_ready=0; send 8'h11 then 8'h22 back-to-back → data_out stays 8'h11 and overrun pulses once at the end of the second frame. Raise data_ready → data_valid drops the next cycle.
- data_ready pulsed high exactly at the completion edge of the second frame (8'h22) → data_out=8'h22, data_valid stays 1, no overrun.
- Assert reset after 4 data bits, release, then send 8'h5A → no spurious output, then data_out=8'h5A. All outputs are 0 during reset.
- Chain siso → sipo_frame_rx; send 8'hC3 into siso.serial_in → data_out=8'hC3, delayed 4 cycles relative to the direct-drive run.
